id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the EX-stage ALU operand muxes.
- Captures decoded operands and control each cycle.
- Resolves the write destination (Rd/Rt) and detects load-use hazards.
- Precomputes the registered forwarding selects EX_AluSrcA_Sel / EX_AluSrcB_Sel, so EX sees stable mux selects at the start of its cycle.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register-address width
- ALUOP_W, 4, ALU opcode width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Hold  in  1  freeze all stage contents (whole-pipeline stall)
- Flush  in  1  replace next EX contents with a bubble (branch/jump taken)
- ID_Valid  in  1  ID holds a real instruction
- ID_Reg1, ID_Reg2  in  DATA_W  register-file read data
- ID_Imm  in  DATA_W  extended immediate
- ID_Rs, ID_Rt, ID_Rd  in  REG_AW  source/destination fields
- ID_UsesRs, ID_UsesRt  in  1  instruction reads Rs/Rt
- ID_AluOp  in  ALUOP_W; ID_AluSrcB, ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg  in  1
- MEM_RegWrite  in  1; MEM_WriteReg  in  REG_AW  instruction now in MEM (in WB next cycle)
- EX_Valid  out  1
- EX_Reg1, EX_Reg2, EX_Imm  out  DATA_W
- EX_WriteReg  out  REG_AW
- EX_AluOp  out  ALUOP_W; EX_AluSrcB, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg  out  1
- EX_AluSrcA_Sel, EX_AluSrcB_Sel  out  2  forwarding selects
- Load_Use_Stall  out  1  combinational; tells PC/IF-ID to hold

Behaviour:
- Reset (async, rst_n low): every output register clears to 0; EX_Valid=0; both selects=2'b00.
- Latency: one cycle from ID inputs to EX outputs.

Load-use detection (combinational):
- Load_Use_Stall = EX_Valid & EX_MemRead & (EX_WriteReg != 0) & ((ID_UsesRs & ID_Rs==EX_WriteReg) | (ID_UsesRt & ID_Rt==EX_WriteReg)).
- Forced to 0 while Hold=1.

Priority per clock edge:
- Hold: keep all contents.
- Flush: load bubble.
- Load_Use_Stall: load bubble.
- Otherwise: load ID inputs.
- Bubble means EX_Valid=0, all control bits 0, selects 00. Data fields are don't-care; they are loaded from ID.

Write destination:
- EX_WriteReg <= ID_RegDst ? ID_Rd : ID_Rt.
- Register 0 is never a forwarding source.

Forwarding select, evaluated per operand x in {Rs→A, Rt→B} on a load cycle:
- 2'b10 (MEM_AluResult) if EX_Valid & EX_RegWrite & (EX_WriteReg != 0) & (EX_WriteReg == x). The instruction currently in EX moves to MEM.
- Else 2'b01 (WriteBackData) if MEM_RegWrite & (MEM_WriteReg != 0) & (MEM_WriteReg == x).
- Else 2'b00.
- The MEM-path match wins over the WB-path match when both hit (youngest producer).
- Sel B is computed from Rt even when ID_AluSrcB=1; the downstream mux ignores it.
- ID_Valid=0 loads as a bubble (selects 00).

Hold:
- The whole pipeline is frozen, so the held selects stay correct.
- Flush during Hold is ignored; the requester must keep Flush asserted.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: adds outputs Perf_Stall_Cnt[31:0] and Perf_Flush_Cnt[31:0].
  - Stall counter increments on each edge where Load_Use_Stall=1 and Hold=0.
  - Flush counter increments on each edge where Flush=1 and Hold=0.
  - Both wrap at 2^32 and reset to 0.
- Undefined: no ports, no counters; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_ZERO=5'd0
  - ALUOP_W
  - a control-bundle typedef (AluOp, AluSrcB, RegWrite, MemRead, MemWrite, MemToReg)
- Sub-module fwd_sel_gen: combinational, one instance per operand.
  - Inputs: source reg, EX/MEM producer info.
  - Output: 2-bit select.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with registers loaded → all outputs 0 immediately, no clock edge needed.
- EX-to-EX forward:
  - Cycle 1: ADD $3,$1,$2 (RegWrite, Rd=3) loads.
  - Cycle 2: SUB $4,$3,$5 → EX_AluSrcA_Sel=10, EX_AluSrcB_Sel=00.
- WB forward with priority:
  - MEM_WriteReg=5, MEM_RegWrite=1, EX producer writes 7; ID Rs=5, Rt=7 → next cycle A=01, B=10.
  - Repeat with both producers writing 7 → B=10.
- Load-use:
  - EX holds LW $8 (MemRead, WriteReg=8); ID Rt=8, UsesRt=1 → Load_Use_Stall=1.
  - Next cycle EX_Valid=0, controls 0.
  - Same case with UsesRt=0 → no stall.
- Zero register: producer writes $0, ID Rs=0 → select 00; no stall for LW $0.
- Hold/Flush interplay:
  - Hold=1,Flush=1 → contents unchanged.
  - Hold=0,Flush=1 with a pending stall → bubble.
  - With PIPE_PERF_CNT_EN defined, Perf_Flush_Cnt increments by exactly 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: constants and types shared by the ID/EX pipeline stage.
//   FWD_*    : ALU operand forwarding-select encodings
//   REG_ZERO : hard-wired zero register, never a forwarding source
//   ALUOP_W  : ALU opcode width
//   ctrlBundle_t : decoded control bits carried from ID into EX
package pipe_pkg;

    localparam int unsigned ALUOP_W = 4;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ALUOP_W-1:0] AluOp;
        logic               AluSrcB;
        logic               RegWrite;
        logic               MemRead;
        logic               MemWrite;
        logic               MemToReg;
    } ctrlBundle_t;

endpackage

// File: rtl/fwd_sel_gen.sv
// fwd_sel_gen: combinational forwarding-select generator for one ALU operand.
// Ports:
//   srcReg       in  source register the next EX instruction reads
//   exValid      in  instruction currently in EX is real
//   exRegWrite   in  EX instruction writes the register file
//   exWriteReg   in  EX instruction destination (moves to MEM next cycle)
//   memRegWrite  in  MEM instruction writes the register file
//   memWriteReg  in  MEM instruction destination (moves to WB next cycle)
//   fwdSel       out FWD_MEM / FWD_WB / FWD_NONE
module fwd_sel_gen #(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] srcReg,
    input  logic              exValid,
    input  logic              exRegWrite,
    input  logic [REG_AW-1:0] exWriteReg,
    input  logic              memRegWrite,
    input  logic [REG_AW-1:0] memWriteReg,
    output logic [1:0]        fwdSel
);
    import pipe_pkg::*;

    logic exHit;
    logic memHit;

    assign exHit  = exValid && exRegWrite && (exWriteReg != REG_AW'(REG_ZERO)) &&
                    (exWriteReg == srcReg);
    assign memHit = memRegWrite && (memWriteReg != REG_AW'(REG_ZERO)) &&
                    (memWriteReg == srcReg);

    // The EX producer is younger than the MEM producer, so it wins.
    always_comb begin
        fwdSel = FWD_NONE;
        if (exHit) begin
            fwdSel = FWD_MEM;
        end else if (memHit) begin
            fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the EX-stage ALU operand muxes.
// Captures decoded operands/control, resolves the write destination, detects
// load-use hazards and registers the forwarding selects for both ALU operands.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   Hold                   freeze all contents (whole-pipeline stall)
//   Flush                  load a bubble (taken branch/jump)
//   ID_*                   decoded instruction in ID
//   MEM_RegWrite/WriteReg  producer currently in MEM
//   EX_*                   registered stage contents and forwarding selects
//   Load_Use_Stall         combinational; holds PC and IF/ID
//   Perf_Stall_Cnt/Perf_Flush_Cnt  only when PIPE_PERF_CNT_EN is defined
// Optional feature macro: PIPE_PERF_CNT_EN (stall/flush event counters).
module id_ex_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    // Must equal pipe_pkg::ALUOP_W, which sizes the control bundle.
    parameter int unsigned ALUOP_W = pipe_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Hold,
    input  logic               Flush,
    input  logic               ID_Valid,
    input  logic [DATA_W-1:0]  ID_Reg1,
    input  logic [DATA_W-1:0]  ID_Reg2,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic [REG_AW-1:0]  ID_Rs,
    input  logic [REG_AW-1:0]  ID_Rt,
    input  logic [REG_AW-1:0]  ID_Rd,
    input  logic               ID_UsesRs,
    input  logic               ID_UsesRt,
    input  logic [ALUOP_W-1:0] ID_AluOp,
    input  logic               ID_AluSrcB,
    input  logic               ID_RegDst,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemToReg,
    input  logic               MEM_RegWrite,
    input  logic [REG_AW-1:0]  MEM_WriteReg,
    output logic               EX_Valid,
    output logic [DATA_W-1:0]  EX_Reg1,
    output logic [DATA_W-1:0]  EX_Reg2,
    output logic [DATA_W-1:0]  EX_Imm,
    output logic [REG_AW-1:0]  EX_WriteReg,
    output logic [ALUOP_W-1:0] EX_AluOp,
    output logic               EX_AluSrcB,
    output logic               EX_RegWrite,
    output logic               EX_MemRead,
    output logic               EX_MemWrite,
    output logic               EX_MemToReg,
    output logic [1:0]         EX_AluSrcA_Sel,
    output logic [1:0]         EX_AluSrcB_Sel,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]        Perf_Stall_Cnt,
    output logic [31:0]        Perf_Flush_Cnt,
`endif
    output logic               Load_Use_Stall
);
    import pipe_pkg::*;

    logic               exValidQ,    exValidD;
    ctrlBundle_t        exCtrlQ,     exCtrlD;
    logic [DATA_W-1:0]  exReg1Q,     exReg1D;
    logic [DATA_W-1:0]  exReg2Q,     exReg2D;
    logic [DATA_W-1:0]  exImmQ,      exImmD;
    logic [REG_AW-1:0]  exWriteRegQ, exWriteRegD;
    logic [1:0]         selAQ,       selAD;
    logic [1:0]         selBQ,       selBD;

    ctrlBundle_t idCtrl;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic        srcHit;
    logic        loadUseStall;
    logic        loadBubble;

    assign idCtrl = '{AluOp:    ID_AluOp,
                      AluSrcB:  ID_AluSrcB,
                      RegWrite: ID_RegWrite,
                      MemRead:  ID_MemRead,
                      MemWrite: ID_MemWrite,
                      MemToReg: ID_MemToReg};

    // Load in EX whose result is needed by ID next cycle: no path can supply it.
    assign srcHit = (ID_UsesRs && (ID_Rs == exWriteRegQ)) ||
                    (ID_UsesRt && (ID_Rt == exWriteRegQ));
    assign loadUseStall = !Hold && exValidQ && exCtrlQ.MemRead &&
                          (exWriteRegQ != REG_AW'(REG_ZERO)) && srcHit;
    assign loadBubble   = Flush || loadUseStall || !ID_Valid;

    fwd_sel_gen #(.REG_AW(REG_AW)) u_fwdA (
        .srcReg      (ID_Rs),
        .exValid     (exValidQ),
        .exRegWrite  (exCtrlQ.RegWrite),
        .exWriteReg  (exWriteRegQ),
        .memRegWrite (MEM_RegWrite),
        .memWriteReg (MEM_WriteReg),
        .fwdSel      (fwdA)
    );

    // Computed from Rt even for immediate forms; the B mux ignores it then.
    fwd_sel_gen #(.REG_AW(REG_AW)) u_fwdB (
        .srcReg      (ID_Rt),
        .exValid     (exValidQ),
        .exRegWrite  (exCtrlQ.RegWrite),
        .exWriteReg  (exWriteRegQ),
        .memRegWrite (MEM_RegWrite),
        .memWriteReg (MEM_WriteReg),
        .fwdSel      (fwdB)
    );

    always_comb begin
        exValidD    = exValidQ;
        exCtrlD     = exCtrlQ;
        exReg1D     = exReg1Q;
        exReg2D     = exReg2Q;
        exImmD      = exImmQ;
        exWriteRegD = exWriteRegQ;
        selAD       = selAQ;
        selBD       = selBQ;
        if (!Hold) begin
            // Data fields load even for bubbles; only control is squashed.
            exReg1D     = ID_Reg1;
            exReg2D     = ID_Reg2;
            exImmD      = ID_Imm;
            exWriteRegD = ID_RegDst ? ID_Rd : ID_Rt;
            if (loadBubble) begin
                exValidD = 1'b0;
                exCtrlD  = '0;
                selAD    = FWD_NONE;
                selBD    = FWD_NONE;
            end else begin
                exValidD = 1'b1;
                exCtrlD  = idCtrl;
                selAD    = fwdA;
                selBD    = fwdB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exValidQ    <= 1'b0;
            exCtrlQ     <= '0;
            exReg1Q     <= '0;
            exReg2Q     <= '0;
            exImmQ      <= '0;
            exWriteRegQ <= '0;
            selAQ       <= FWD_NONE;
            selBQ       <= FWD_NONE;
        end else begin
            exValidQ    <= exValidD;
            exCtrlQ     <= exCtrlD;
            exReg1Q     <= exReg1D;
            exReg2Q     <= exReg2D;
            exImmQ      <= exImmD;
            exWriteRegQ <= exWriteRegD;
            selAQ       <= selAD;
            selBQ       <= selBD;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stallCntQ;
    logic [31:0] flushCntQ;

    // loadUseStall is already masked by Hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (loadUseStall) begin
                stallCntQ <= stallCntQ + 32'd1;
            end
            if (Flush && !Hold) begin
                flushCntQ <= flushCntQ + 32'd1;
            end
        end
    end

    assign Perf_Stall_Cnt = stallCntQ;
    assign Perf_Flush_Cnt = flushCntQ;
`endif

    assign EX_Valid       = exValidQ;
    assign EX_Reg1        = exReg1Q;
    assign EX_Reg2        = exReg2Q;
    assign EX_Imm         = exImmQ;
    assign EX_WriteReg    = exWriteRegQ;
    assign EX_AluOp       = exCtrlQ.AluOp;
    assign EX_AluSrcB     = exCtrlQ.AluSrcB;
    assign EX_RegWrite    = exCtrlQ.RegWrite;
    assign EX_MemRead     = exCtrlQ.MemRead;
    assign EX_MemWrite    = exCtrlQ.MemWrite;
    assign EX_MemToReg    = exCtrlQ.MemToReg;
    assign EX_AluSrcA_Sel = selAQ;
    assign EX_AluSrcB_Sel = selBQ;
    assign Load_Use_Stall = loadUseStall;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven bench for id_ex_stage. Each vector drives one
// cycle of ID/MEM/control inputs, checks the combinational stall before the
// edge and the registered EX contents after it. Reset is checked by hand.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Hold = 1'b0, Flush = 1'b0, ID_Valid = 1'b0;
    logic [31:0] ID_Reg1 = '0, ID_Reg2 = '0, ID_Imm = '0;
    logic [4:0]  ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
    logic        ID_UsesRs = 1'b0, ID_UsesRt = 1'b0;
    logic [3:0]  ID_AluOp = '0;
    logic        ID_AluSrcB = 1'b0, ID_RegDst = 1'b0, ID_RegWrite = 1'b0;
    logic        ID_MemRead = 1'b0, ID_MemWrite = 1'b0, ID_MemToReg = 1'b0;
    logic        MEM_RegWrite = 1'b0;
    logic [4:0]  MEM_WriteReg = '0;
    logic        EX_Valid;
    logic [31:0] EX_Reg1, EX_Reg2, EX_Imm;
    logic [4:0]  EX_WriteReg;
    logic [3:0]  EX_AluOp;
    logic        EX_AluSrcB, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg;
    logic [1:0]  EX_AluSrcA_Sel, EX_AluSrcB_Sel;
    logic        Load_Use_Stall;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] Perf_Stall_Cnt, Perf_Flush_Cnt;
`endif

    id_ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Hold           (Hold),
        .Flush          (Flush),
        .ID_Valid       (ID_Valid),
        .ID_Reg1        (ID_Reg1),
        .ID_Reg2        (ID_Reg2),
        .ID_Imm         (ID_Imm),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_Rd          (ID_Rd),
        .ID_UsesRs      (ID_UsesRs),
        .ID_UsesRt      (ID_UsesRt),
        .ID_AluOp       (ID_AluOp),
        .ID_AluSrcB     (ID_AluSrcB),
        .ID_RegDst      (ID_RegDst),
        .ID_RegWrite    (ID_RegWrite),
        .ID_MemRead     (ID_MemRead),
        .ID_MemWrite    (ID_MemWrite),
        .ID_MemToReg    (ID_MemToReg),
        .MEM_RegWrite   (MEM_RegWrite),
        .MEM_WriteReg   (MEM_WriteReg),
        .EX_Valid       (EX_Valid),
        .EX_Reg1        (EX_Reg1),
        .EX_Reg2        (EX_Reg2),
        .EX_Imm         (EX_Imm),
        .EX_WriteReg    (EX_WriteReg),
        .EX_AluOp       (EX_AluOp),
        .EX_AluSrcB     (EX_AluSrcB),
        .EX_RegWrite    (EX_RegWrite),
        .EX_MemRead     (EX_MemRead),
        .EX_MemWrite    (EX_MemWrite),
        .EX_MemToReg    (EX_MemToReg),
        .EX_AluSrcA_Sel (EX_AluSrcA_Sel),
        .EX_AluSrcB_Sel (EX_AluSrcB_Sel),
`ifdef PIPE_PERF_CNT_EN
        .Perf_Stall_Cnt (Perf_Stall_Cnt),
        .Perf_Flush_Cnt (Perf_Flush_Cnt),
`endif
        .Load_Use_Stall (Load_Use_Stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       uRs, uRt;
        logic [3:0] op;
        logic       regDst, rw, mr, v, hold, flush, mRw;
        logic [4:0] mWr;
        logic       eStall, eValid;
        logic [4:0] eWr;
        logic       eWrChk;
        logic [3:0] eOp;
        logic       eRw, eMr;
        logic [1:0] eA, eB;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic uRs, input logic uRt, input logic [3:0] op,
        input logic regDst, input logic rw, input logic mr, input logic v,
        input logic hold, input logic flush, input logic mRw, input logic [4:0] mWr,
        input logic eStall, input logic eValid, input logic [4:0] eWr, input logic eWrChk,
        input logic [3:0] eOp, input logic eRw, input logic eMr,
        input logic [1:0] eA, input logic [1:0] eB);
        vec_t t;
        t.rs = rs; t.rt = rt; t.rd = rd; t.uRs = uRs; t.uRt = uRt; t.op = op;
        t.regDst = regDst; t.rw = rw; t.mr = mr; t.v = v; t.hold = hold;
        t.flush = flush; t.mRw = mRw; t.mWr = mWr; t.eStall = eStall;
        t.eValid = eValid; t.eWr = eWr; t.eWrChk = eWrChk; t.eOp = eOp;
        t.eRw = eRw; t.eMr = eMr; t.eA = eA; t.eB = eB;
        return t;
    endfunction

    vec_t vecs[20];
    logic [31:0] expReg1;

    initial begin
        // rs rt rd uRs uRt op dst rw mr v hold flush mRw mWr | stall vld wr chk op rw mr A B
        vecs[0]  = mk(1, 2, 3,  1,1,2,1,1,0,1,0,0,0,0, 0,1,3, 1,2,1,0,2'b00,2'b00); // ADD $3
        vecs[1]  = mk(3, 5, 4,  1,1,6,1,1,0,1,0,0,0,0, 0,1,4, 1,6,1,0,2'b10,2'b00); // SUB $4,$3
        vecs[2]  = mk(0, 0, 7,  1,1,2,1,1,0,1,0,0,0,0, 0,1,7, 1,2,1,0,2'b00,2'b00); // writes $7
        vecs[3]  = mk(5, 7, 9,  1,1,2,1,1,0,1,0,0,1,5, 0,1,9, 1,2,1,0,2'b01,2'b10); // WB A, MEM B
        vecs[4]  = mk(0, 0, 7,  1,1,2,1,1,0,1,0,0,0,0, 0,1,7, 1,2,1,0,2'b00,2'b00);
        vecs[5]  = mk(1, 7, 10, 1,1,2,1,1,0,1,0,0,1,7, 0,1,10,1,2,1,0,2'b00,2'b10); // both hit 7
        vecs[6]  = mk(1, 8, 0,  1,0,0,0,1,1,1,0,0,0,0, 0,1,8, 1,0,1,1,2'b00,2'b00); // LW $8
        vecs[7]  = mk(2, 8, 11, 1,1,2,1,1,0,1,0,0,0,0, 1,0,11,0,0,0,0,2'b00,2'b00); // load-use
        vecs[8]  = mk(1, 8, 0,  1,0,0,0,1,1,1,0,0,0,0, 0,1,8, 1,0,1,1,2'b00,2'b00); // LW $8
        vecs[9]  = mk(2, 8, 11, 1,0,2,1,1,0,1,0,0,0,0, 0,1,11,1,2,1,0,2'b00,2'b10); // UsesRt=0
        vecs[10] = mk(0, 0, 0,  1,1,2,1,1,0,1,0,0,0,0, 0,1,0, 1,2,1,0,2'b00,2'b00); // writes $0
        vecs[11] = mk(0, 0, 12, 1,1,2,1,1,0,1,0,0,1,0, 0,1,12,1,2,1,0,2'b00,2'b00); // $0 source
        vecs[12] = mk(1, 0, 0,  1,0,0,0,1,1,1,0,0,0,0, 0,1,0, 1,0,1,1,2'b00,2'b00); // LW $0
        vecs[13] = mk(0, 3, 13, 1,1,2,1,1,0,1,0,0,1,3, 0,1,13,1,2,1,0,2'b00,2'b01); // no stall
        vecs[14] = mk(13,13,14, 1,1,5,1,1,0,1,1,1,0,0, 0,1,13,1,2,1,0,2'b00,2'b01); // hold+flush
        vecs[15] = mk(1, 8, 0,  1,0,0,0,1,1,1,0,0,0,0, 0,1,8, 1,0,1,1,2'b00,2'b00); // LW $8
        vecs[16] = mk(2, 8, 11, 1,1,2,1,1,0,1,1,0,0,0, 0,1,8, 1,0,1,1,2'b00,2'b00); // hold masks
        vecs[17] = mk(2, 8, 11, 1,1,2,1,1,0,1,0,1,0,0, 1,0,11,0,0,0,0,2'b00,2'b00); // flush+stall
        vecs[18] = mk(5, 0, 3,  1,1,2,1,1,0,0,0,0,1,5, 0,0,3, 0,0,0,0,2'b00,2'b00); // ID_Valid=0
        vecs[19] = mk(5, 0, 3,  1,1,2,1,1,0,1,0,0,1,5, 0,1,3, 1,2,1,0,2'b01,2'b00);

        repeat (2) @(posedge clk);
        #1;
        check("reset EX_Valid", 32'(EX_Valid), 32'd0);
        check("reset EX_WriteReg", 32'(EX_WriteReg), 32'd0);
        check("reset sels", 32'({EX_AluSrcA_Sel, EX_AluSrcB_Sel}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expReg1 = '0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt; ID_Rd = vecs[i].rd;
            ID_UsesRs = vecs[i].uRs; ID_UsesRt = vecs[i].uRt; ID_AluOp = vecs[i].op;
            ID_RegDst = vecs[i].regDst; ID_RegWrite = vecs[i].rw;
            ID_MemRead = vecs[i].mr; ID_MemToReg = vecs[i].mr; ID_AluSrcB = vecs[i].mr;
            ID_MemWrite = 1'b0; ID_Valid = vecs[i].v;
            Hold = vecs[i].hold; Flush = vecs[i].flush;
            MEM_RegWrite = vecs[i].mRw; MEM_WriteReg = vecs[i].mWr;
            ID_Reg1 = 32'hA500_0000 | 32'(i); ID_Reg2 = ~ID_Reg1; ID_Imm = 32'(i);
            if (!vecs[i].hold) expReg1 = ID_Reg1;
            #1;
            check($sformatf("v%0d Load_Use_Stall", i), 32'(Load_Use_Stall), 32'(vecs[i].eStall));
            @(posedge clk);
            #1;
            check($sformatf("v%0d EX_Valid", i), 32'(EX_Valid), 32'(vecs[i].eValid));
            if (vecs[i].eWrChk)
                check($sformatf("v%0d EX_WriteReg", i), 32'(EX_WriteReg), 32'(vecs[i].eWr));
            check($sformatf("v%0d EX_AluOp", i), 32'(EX_AluOp), 32'(vecs[i].eOp));
            check($sformatf("v%0d EX_RegWrite", i), 32'(EX_RegWrite), 32'(vecs[i].eRw));
            check($sformatf("v%0d EX_MemRead", i), 32'(EX_MemRead), 32'(vecs[i].eMr));
            check($sformatf("v%0d EX_MemToReg", i), 32'(EX_MemToReg), 32'(vecs[i].eMr));
            check($sformatf("v%0d EX_AluSrcB", i), 32'(EX_AluSrcB), 32'(vecs[i].eMr));
            check($sformatf("v%0d EX_AluSrcA_Sel", i), 32'(EX_AluSrcA_Sel), 32'(vecs[i].eA));
            check($sformatf("v%0d EX_AluSrcB_Sel", i), 32'(EX_AluSrcB_Sel), 32'(vecs[i].eB));
            check($sformatf("v%0d EX_Reg1", i), EX_Reg1, expReg1);
        end

`ifdef PIPE_PERF_CNT_EN
        // Stall edges: v7, v17. Flush without hold: v17 only.
        check("Perf_Stall_Cnt", Perf_Stall_Cnt, 32'd2);
        check("Perf_Flush_Cnt", Perf_Flush_Cnt, 32'd1);
`endif

        // Asynchronous reset mid-cycle with EX loaded (v19 content).
        check("pre-reset EX_Valid", 32'(EX_Valid), 32'd1);
        Hold = 1'b0; Flush = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async EX_Valid", 32'(EX_Valid), 32'd0);
        check("async EX_WriteReg", 32'(EX_WriteReg), 32'd0);
        check("async EX_AluOp", 32'(EX_AluOp), 32'd0);
        check("async EX_RegWrite", 32'(EX_RegWrite), 32'd0);
        check("async EX_AluSrcA_Sel", 32'(EX_AluSrcA_Sel), 32'd0);
        check("async EX_Reg1", EX_Reg1, 32'd0);
        check("async EX_Imm", EX_Imm, 32'd0);
`ifdef PIPE_PERF_CNT_EN
        check("async Perf_Flush_Cnt", Perf_Flush_Cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
